seq_detector_1010: RTL and testbench
====================================

// Module: seq_detector_1010
//
// PURPOSE
//   Overlapping Mealy detector for the serial bit pattern 1-0-1-0 on input x.
//   Samples one bit per rising clock edge. Asserts z in the same cycle as the
//   final '0' of each match.
//   Overlap is allowed: the trailing "10" of one match starts the next
//   ("101010" yields two matches).
//   Standalone leaf block in the serial-protocol front end.
//
// PARAMETERS
//   None. The pattern is fixed at 4'b1010, MSB first in time.
//
// PORTS
//   clk    input   1  rising-edge clock; the only clock
//   rst_n  input   1  reset, synchronous, active-low
//   x      input   1  serial data bit, sampled on rising clk
//   z      output  1  match flag, high for the cycle in which "1010" completes
//
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-low (rst_n).
//   - Reset: on any rising clk with rst_n=0, state <= S0.
//     z is forced 0 for the whole time rst_n=0, independent of state or x.
//   - States (2-bit encoding):
//     S0 = idle, S1 = seen "1", S10 = seen "10", S101 = seen "101".
//   - Transitions on rising clk (rst_n=1):
//       S0  : x=1 -> S1,   x=0 -> S0
//       S1  : x=1 -> S1,   x=0 -> S10
//       S10 : x=1 -> S101, x=0 -> S0
//       S101: x=1 -> S1,   x=0 -> S10 (match; overlap keeps "10")
//   - Mealy output (default build): z = rst_n & (state==S101) & ~x.
//     z is purely combinational from state and x.
//     Zero latency: z is valid in the cycle the final bit is presented.
//   - Any unused or illegal state encoding returns to S0 on the next edge,
//     with z=0.
//   - Back-to-back overlapping matches are spaced 2 cycles apart.
//     z is never high in two consecutive cycles.
//   - Reset deasserting mid-pattern: detection restarts from S0.
//     Bits received before reset never contribute to a match.
//   - x is expected to be stable around rising clk. No internal synchroniser.
//
// CONFIGURATION
//   SEQ_DET_REG_OUT_EN
//     - Undefined (default): Mealy z as above, combinational, 0-cycle latency.
//     - Defined: z comes from a flop, z_q <= rst_n & (state==S101) & ~x.
//       The pulse appears one cycle later, lasts exactly one cycle and is
//       glitch-free.
//       Synchronous reset clears z_q to 0.
//     - State machine and transitions are identical in both builds.
//
// TESTING
//   1. Hold rst_n=0 for 2 edges with x toggling -> z=0 throughout.
//      After release, state is S0.
//   2. Drive x = 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 (bits 1..15, one per cycle)
//      -> z=1 only on bits 5, 7, 13, 15; z=0 on bit 11 and all other bits.
//   3. Drive x = 1,0,1,1,0,1,0 -> a single z pulse, on bit 7
//      (the "11" restarts the search from S1).
//   4. Reach S101 (x=1,0,1), then assert rst_n=0 while x=0
//      -> z stays 0. After release, x=0 gives no match.
//   5. Drive all-zeros or all-ones for 20 cycles -> z never asserts.
//   6. Build with SEQ_DET_REG_OUT_EN and rerun test 2
//      -> z pulses on bits 6, 8, 14, 16, each one cycle wide.

Source files
------------

// File: rtl/seq_detector_1010.sv
// -----------------------------------------------------------------------------
// seq_detector_1010
//
// Purpose:
//   Overlapping detector for the serial bit pattern 1-0-1-0 on x, one bit per
//   rising clk edge. The trailing "10" of a match seeds the next one, so
//   "101010" yields two matches.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  synchronous active-low reset
//   x      in   1  serial data bit, sampled on rising clk
//   z      out  1  match flag, one cycle wide per completed "1010"
//
// Configuration:
//   SEQ_DET_REG_OUT_EN
//     undefined : z is Mealy (combinational from state and x), 0-cycle latency
//     defined   : z is registered, pulse appears one cycle later, glitch-free
//   The state machine is identical in both builds.
// -----------------------------------------------------------------------------
module seq_detector_1010 (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic z
);

    typedef enum logic [1:0] {
        S0   = 2'b00,  // idle
        S1   = 2'b01,  // seen "1"
        S10  = 2'b10,  // seen "10"
        S101 = 2'b11   // seen "101"
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_match;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and match logic
    always_comb begin
        w_state_next = S0;
        w_match      = 1'b0;
        case (r_state)
            S0:      w_state_next = x ? S1   : S0;
            S1:      w_state_next = x ? S1   : S10;
            S10:     w_state_next = x ? S101 : S0;
            S101:    w_state_next = x ? S1   : S10;  // x=0 is a match; keep "10"
            default: w_state_next = S0;
        endcase
        // Reset gates the flag so it is low for the whole time rst_n is low.
        w_match = rst_n & (r_state == S101) & ~x;
    end

`ifdef SEQ_DET_REG_OUT_EN
    logic r_z;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_z <= 1'b0;
        end else begin
            r_z <= w_match;
        end
    end

    assign z = r_z;
`else
    assign z = w_match;
`endif

endmodule

// File: tb/tb_seq_detector_1010.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_1010
//
// Directed bench for seq_detector_1010. Each step drives x (and rst_n) after
// the falling edge and samples z shortly before the next rising edge. The
// expected Mealy flag for every bit is hand-computed; in the registered build
// the expectation is delayed by one cycle.
// -----------------------------------------------------------------------------
module tb_seq_detector_1010;

    logic clk;
    logic rst_n;
    logic x;
    logic z;

    int n_checks;
    int n_errors;
    logic exp_prev;  // Mealy expectation from the previous cycle

    seq_detector_1010 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got z=%b, expected z=%b", tag, got, exp);
        end
    endtask

    // Drive one bit for one cycle and check z; exp_mealy is the combinational
    // flag expected for this cycle (already 0 whenever rst_n is 0).
    task automatic step(input logic rst_v, input logic xv, input logic exp_mealy,
                        input string tag);
        logic exp_now;
        @(negedge clk);
        rst_n = rst_v;
        x     = xv;
        #2;
`ifdef SEQ_DET_REG_OUT_EN
        exp_now = exp_prev;
`else
        exp_now = exp_mealy;
`endif
        check_eq(tag, z, exp_now);
        exp_prev = exp_mealy;
    endtask

    logic [14:0] t2_x;
    logic [14:0] t2_z;
    logic [6:0]  t3_x;
    logic [6:0]  t3_z;

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_prev = 1'b0;
        rst_n    = 1'b0;
        x        = 1'b0;
        // One uncounted reset edge so the registered build starts defined.
        @(posedge clk);

        // Test 1: reset held for 2 edges with x toggling.
        step(1'b0, 1'b1, 1'b0, "t1_rst_a");
        step(1'b0, 1'b0, 1'b0, "t1_rst_b");
        step(1'b0, 1'b1, 1'b0, "t1_rst_c");

        // Test 2: bits 1..15 listed left to right (index 14 is bit 1).
        t2_x = 15'b110101011101010;
        t2_z = 15'b000010100000101;
        for (int i = 14; i >= 0; i--) begin
            step(1'b1, t2_x[i], t2_z[i], $sformatf("t2_bit%0d", 15 - i));
        end

        // Reset between tests so prior state cannot seed a match.
        step(1'b0, 1'b0, 1'b0, "t3_rst");

        // Test 3: "11" restarts from S1; single match on bit 7.
        t3_x = 7'b1011010;
        t3_z = 7'b0000001;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, t3_x[i], t3_z[i], $sformatf("t3_bit%0d", 7 - i));
        end

        step(1'b0, 1'b0, 1'b0, "t4_rst_pre");

        // Test 4: reach S101, then reset with x=0 must suppress the match.
        step(1'b1, 1'b1, 1'b0, "t4_b1");
        step(1'b1, 1'b0, 1'b0, "t4_b2");
        step(1'b1, 1'b1, 1'b0, "t4_b3");
        step(1'b0, 1'b0, 1'b0, "t4_rst_in_s101");
        step(1'b1, 1'b0, 1'b0, "t4_after_rel");
        step(1'b1, 1'b0, 1'b0, "t4_after_rel2");

        // Test 5: all zeros, then all ones, 20 cycles each.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, $sformatf("t5_zero%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, $sformatf("t5_one%0d", i));
        end

        // Tail: overlap "1010" from S1 (already in S1 after the ones).
        step(1'b1, 1'b0, 1'b0, "tail_b1");
        step(1'b1, 1'b1, 1'b0, "tail_b2");
        step(1'b1, 1'b0, 1'b1, "tail_b3");
        step(1'b1, 1'b0, 1'b0, "tail_b4");
        step(1'b1, 1'b0, 1'b0, "tail_b5");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
